ex_addsub_stage: RTL
====================

# ex_addsub_stage

Pipelined execute-stage wrapper around the team's saturating 16-bit add/subtract datapath (`cla_16bit`). It accepts ADD, SUB, accumulate and clear operations over a valid/ready handshake. It registers operands into an adder stage, then registers the saturated result together with its N/Z/V flags into an output stage. It sits between decode/issue and writeback, and it owns a 16-bit saturating accumulator and a sticky saturation status bit.

## Interface
Parameters:
- `WIDTH`, 16: datapath width; only 16 is supported, because `cla_16bit` is fixed-width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  stage accepts the operation this cycle.
- `in_op`  in  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- `in_a`  in  16  operand A, two's complement (ignored for ACC and CLR).
- `in_b`  in  16  operand B, two's complement (ignored for CLR).
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `out_result`  out  16  saturated result.
- `out_flags`  out  3  {N, Z, V}.
- `acc_value`  out  16  current accumulator register.
- `sat_sticky`  out  1  set by any V=1 result; cleared only by CLR or reset.

## Operation
- Two registered stages: S1 (operands and op) and S2 (result and flags). The adder sits combinationally between S1 and S2.
- Adder inputs, selected from S1:
  - ADD: A = s1_a, B = s1_b, sub = 0.
  - SUB: A = s1_a, B = s1_b, sub = 1.
  - ACC: A = acc_value, B = s1_b, sub = 0.
  - CLR: the adder output is ignored, and result is forced to 0x0000 with V = 0.
- Arithmetic is signed 16-bit with saturation:
  - Positive overflow gives 0x7FFF with V = 1.
  - Negative overflow gives 0x8000 with V = 1.
  - Otherwise the result is the wrapped sum and V = 0.
- Flags: N = result[15]; Z = (result == 0); V = overflow from the adder.
- Accumulator: written with the saturated result on the edge where an ACC op moves from S1 to S2. CLR writes 0 on its S1→S2 edge. ADD and SUB never touch it.
- ACC reads `acc_value` while in S1, never at input time, so back-to-back ACC ops chain with no bubble and no forwarding.
- `sat_sticky` is set on the S1→S2 edge of any op producing V = 1. CLR clears it on its edge; CLR itself never sets it.

## Timing
- Reset (asynchronous, immediate) drives:
  - s1_valid = 0 and s2_valid = 0, so out_valid = 0;
  - out_result = 0x0000 and out_flags = 3'b010 (Z = 1);
  - acc_value = 0x0000 and sat_sticky = 0.
- Latency is 2 cycles: an op accepted at edge t appears with out_valid = 1 after edge t+1, provided there are no stalls. Throughput is 1 op per cycle.
- Stall rules:
  - S2 advances when !s2_valid or out_ready.
  - S1 advances when it is empty or S2 advances.
  - in_ready = !s1_valid || s2_advance, combinational from out_ready.
- Handshakes: a transfer occurs when valid && ready on the same edge. While out_valid = 1 and out_ready = 0, out_result and out_flags hold stable.
- Accumulator and sticky updates happen only on S1→S2 transfers. A stalled ACC in S1 updates nothing until it moves.
- Simultaneous S2 drain and S1 fill in one edge are legal and lose nothing.
- Reset mid-operation discards all in-flight ops. No partial accumulator write survives.

## Structure
- Shared package `addsub_pkg` holds:
  - the op encoding constants OP_ADD, OP_SUB, OP_ACC, OP_CLR;
  - flag bit indices FLAG_N = 2, FLAG_Z = 1, FLAG_V = 0;
  - saturation constants SAT_POS = 0x7FFF and SAT_NEG = 0x8000.
- Sub-module: one instance of the existing `cla_16bit`, with cin tied to 0 and `sub` driven from the S1 op. No other sub-modules.
- RTL target is about 150–200 lines.

## Test plan
- Reset then ADD 0x7000 + 0x2000 → out_result 0x7FFF, flags {N0, Z0, V1}, sat_sticky = 1, 2 cycles after acceptance.
- SUB 0x8000 − 0x0001 → 0x8000, {N1, Z0, V1}. Then SUB 0x0000 − 0x8000 → 0x7FFF, V = 1. Then ADD 0x1234 + 0xEDCC → 0x0000, {N0, Z1, V0}.
- CLR, then back-to-back ACC with b = 0x4000, 0x4000, 0x4000 and out_ready held at 1:
  - results are 0x4000 (V0), 0x7FFF (V1), 0x7FFF (V1);
  - acc_value ends at 0x7FFF;
  - a following CLR gives result 0x0000, acc_value 0 and sat_sticky 0.
- Backpressure: stream 4 ADDs with out_ready = 0 for 5 cycles.
  - in_ready drops after 2 accepts.
  - out_result holds stable through the stall.
  - After release, all 4 results emerge in order with no loss or duplication.
- Stalled ACC: hold an ACC in S1 during an out_ready = 0 stall. acc_value must remain unchanged until the cycle the op transfers to S2.
- Reset asserted with ACC ops in both S1 and S2 → outputs return to reset values immediately and acc_value = 0x0000. The first op issued after reset completes normally.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the execute-stage add/subtract slice: op encodings,
// flag bit positions and saturation limits.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  localparam logic signed [15:0] SAT_POS = 16'sh7FFF;
  localparam logic signed [15:0] SAT_NEG = 16'sh8000;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder/subtractor. Four 4-bit groups with lookahead
// across groups; subtraction inverts B and forces the carry-in. Reports the
// raw wrapped sum and signed overflow; saturation is left to the caller.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        ovf
);

  logic [15:0] b_eff;
  logic [15:0] g;
  logic [15:0] p;

  assign b_eff = b ^ {16{sub}};
  assign g     = a & b_eff;
  assign p     = a ^ b_eff;

  // Group generate/propagate, inter-group lookahead and in-group sum bits.
  always_comb begin
    logic       cy;
    logic       cb;
    logic [3:0] gg;
    logic [3:0] pg;
    sum = '0;
    cy  = cin | sub;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
      cb = cy;
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ cb;
        cb         = g[4*k+j] | (p[4*k+j] & cb);
      end
      cy = gg[k] | (pg[k] & cy);
    end
  end

  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf = (a[15] == b_eff[15]) && (sum[15] != a[15]);

endmodule

// File: rtl/ex_addsub_stage.sv
// Two-stage execute wrapper around cla_16bit: S1 holds operands and op, S2
// holds the saturated result and {N,Z,V}. Owns a saturating accumulator and
// a sticky saturation bit, both updated only when an op moves S1 -> S2.
module ex_addsub_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_flags,
  output logic [WIDTH-1:0] acc_value,
  output logic             sat_sticky
);

  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] raw,
    input logic                    ovf,
    input logic                    a_sign
  );
    // Overflow only happens with like-signed operands, so A's sign picks the rail.
    if (!ovf) return raw;
    return a_sign ? SAT_NEG : SAT_POS;
  endfunction

  function automatic logic [2:0] make_flags(
    input logic signed [WIDTH-1:0] r,
    input logic                    v
  );
    logic [2:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_V] = v;
    return f;
  endfunction

  logic                    vld_p1;
  logic                    vld_p2;
  op_e                     op_p1;
  logic signed [WIDTH-1:0] a_p1;
  logic signed [WIDTH-1:0] b_p1;
  logic signed [WIDTH-1:0] result_p2;
  logic [2:0]              flags_p2;
  logic signed [WIDTH-1:0] acc_q;
  logic                    sticky_q;

  logic                    s2_adv;
  logic                    s1_adv;
  logic                    xfer;
  logic signed [WIDTH-1:0] add_a;
  logic signed [WIDTH-1:0] sum_raw;
  logic                    ovf_raw;
  logic                    sub_sel;
  logic signed [WIDTH-1:0] res_next;
  logic                    v_next;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;
  assign xfer     = vld_p1 && s2_adv;

  // ---- S0 -> S1: operand capture ----
  // S1 valid bit; cleared by reset so in-flight ops are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (s1_adv) vld_p1 <= in_valid;
  end

  // S1 operand/op registers load on every accepted op; contents are don't-care when invalid.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      op_p1 <= op_e'(in_op);
      a_p1  <= in_a;
      b_p1  <= in_b;
    end
  end

  // ACC sums the live accumulator read in S1, so back-to-back ACCs chain without forwarding.
  assign add_a   = (op_p1 == OP_ACC) ? acc_q : a_p1;
  assign sub_sel = (op_p1 == OP_SUB);

  cla_16bit u_cla (
    .a   (add_a),
    .b   (b_p1),
    .cin (1'b0),
    .sub (sub_sel),
    .sum (sum_raw),
    .ovf (ovf_raw)
  );

  // Saturate the adder output; CLR overrides it with zero and no overflow.
  always_comb begin
    res_next = saturate(sum_raw, ovf_raw, add_a[WIDTH-1]);
    v_next   = ovf_raw;
    if (op_p1 == OP_CLR) begin
      res_next = '0;
      v_next   = 1'b0;
    end
  end

  // ---- S1 -> S2: result and flags ----
  // S2 register holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      flags_p2  <= make_flags('0, 1'b0);
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        result_p2 <= res_next;
        flags_p2  <= make_flags(res_next, v_next);
      end
    end
  end

  // Accumulator and sticky bit change only on the edge an op leaves S1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else if (xfer) begin
      if (op_p1 == OP_ACC) acc_q <= res_next;
      if (op_p1 == OP_CLR) begin
        acc_q    <= '0;
        sticky_q <= 1'b0;
      end else if (v_next) begin
        sticky_q <= 1'b1;
      end
    end
  end

  assign out_valid  = vld_p2;
  assign out_result = result_p2;
  assign out_flags  = flags_p2;
  assign acc_value  = acc_q;
  assign sat_sticky = sticky_q;

endmodule
